dram_arbiter: RTL

- Shares one DRAM/MMU-side memory port between NHART hart MMUs (cpummu instances).
- Each hart MMU issues single-cycle read (le) or write (we_t) pulses and then waits on its busy.
- The block queues one request per hart, grants round-robin, replays the request to the DRAM controller, and returns busy/odata to the granted hart.
- Sits between the per-hart cpummu DRAM ports and the single DRAM controller.

---
 rtl/dram_arbiter_if.sv | 72 +++++++
 rtl/dram_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: per-hart request buses and the shared DRAM port.
// Optional macro DRAM_ARB_LOCK_EN adds the per-hart w_hart_lock bits.
interface dram_arbiter_if #(
    parameter int NHART = 2,
    parameter int IDX_W = 1
);
    logic [NHART*32-1:0] w_hart_addr;
    logic [NHART*32-1:0] w_hart_wdata;
    logic [NHART*3-1:0]  w_hart_ctrl;
    logic [NHART-1:0]    w_hart_le;
    logic [NHART-1:0]    w_hart_we_t;
    logic [NHART-1:0]    w_hart_busy;
    logic [31:0]         w_hart_odata;
`ifdef DRAM_ARB_LOCK_EN
    logic [NHART-1:0]    w_hart_lock;
`endif
    logic [31:0]         w_dram_addr;
    logic [31:0]         w_dram_wdata;
    logic [2:0]          w_dram_ctrl;
    logic                w_dram_le;
    logic                w_dram_we_t;
    logic                w_dram_busy;
    logic [31:0]         w_dram_odata;
    logic [IDX_W-1:0]    w_grant;
    logic                w_arb_err;

    // Arbiter view
    modport slave (
`ifdef DRAM_ARB_LOCK_EN
        input  w_hart_lock,
`endif
        input  w_hart_addr,
        input  w_hart_wdata,
        input  w_hart_ctrl,
        input  w_hart_le,
        input  w_hart_we_t,
        output w_hart_busy,
        output w_hart_odata,
        output w_dram_addr,
        output w_dram_wdata,
        output w_dram_ctrl,
        output w_dram_le,
        output w_dram_we_t,
        input  w_dram_busy,
        input  w_dram_odata,
        output w_grant,
        output w_arb_err
    );

    // Environment view: harts plus DRAM controller
    modport master (
`ifdef DRAM_ARB_LOCK_EN
        output w_hart_lock,
`endif
        output w_hart_addr,
        output w_hart_wdata,
        output w_hart_ctrl,
        output w_hart_le,
        output w_hart_we_t,
        input  w_hart_busy,
        input  w_hart_odata,
        input  w_dram_addr,
        input  w_dram_wdata,
        input  w_dram_ctrl,
        input  w_dram_le,
        input  w_dram_we_t,
        output w_dram_busy,
        output w_dram_odata,
        input  w_grant,
        input  w_arb_err
    );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin sharing of one DRAM port between NHART hart MMUs.
// Optional macro DRAM_ARB_LOCK_EN keeps the grant on a hart holding w_hart_lock.
module dram_arbiter #(
    parameter int NHART = 2,
    parameter int IDX_W = 1
) (
    input logic           CLK,
    input logic           RST,
    dram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    state_t           state_nx;
    logic [NHART-1:0] pend;
    logic [NHART-1:0] occ;
    logic [NHART-1:0] cap;
    logic [NHART-1:0] req;
    logic [NHART-1:0] mask;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             done;
    logic             viol;
    logic             r_seen;
    logic [31:0]      slot_addr  [NHART];
    logic [31:0]      slot_wdata [NHART];
    logic [2:0]       slot_ctrl  [NHART];
    logic [NHART-1:0] slot_wr;
`ifdef DRAM_ARB_LOCK_EN
    logic             locked;
`endif

    // Slot occupancy, accepted pulses and protocol violations
    always_comb begin
        done = (state == WAIT) && r_seen && !bus.w_dram_busy;
        occ  = pend;
        cap  = '0;
        viol = 1'b0;
        for (int i = 0; i < NHART; i++) begin
            if (state != IDLE && grant == IDX_W'(i) && !done)
                occ[i] = 1'b1;
            if (bus.w_hart_le[i] || bus.w_hart_we_t[i]) begin
                if (occ[i])
                    viol = 1'b1;
                else
                    cap[i] = 1'b1;
                if (bus.w_hart_le[i] && bus.w_hart_we_t[i])
                    viol = 1'b1;
            end
        end
    end

    // Requests eligible for the next grant; same-cycle pulses count too
    always_comb begin
        mask = '1;
`ifdef DRAM_ARB_LOCK_EN
        if (locked) begin
            mask        = '0;
            mask[grant] = 1'b1;
        end
`endif
        req = (pend | cap) & mask;
    end

    // Round-robin pick starting just after the last served hart
    always_comb begin
        found = 1'b0;
        sel   = r_last;
        for (int k = 1; k <= NHART; k++) begin
            if (!found && req[(int'(r_last) + k) % NHART]) begin
                found = 1'b1;
                sel   = IDX_W'((int'(r_last) + k) % NHART);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = ISSUE;
            ISSUE:   if (!bus.w_dram_busy) state_nx = WAIT;
            WAIT:    if (done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.w_hart_busy  = occ;
    assign bus.w_hart_odata = bus.w_dram_odata;
    assign bus.w_grant      = grant;

    // State, slots and registered DRAM-side outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state            <= IDLE;
            pend             <= '0;
            grant            <= '0;
            r_last           <= IDX_W'(NHART - 1);
            r_seen           <= 1'b0;
            bus.w_dram_le    <= 1'b0;
            bus.w_dram_we_t  <= 1'b0;
            bus.w_dram_addr  <= '0;
            bus.w_dram_wdata <= '0;
            bus.w_dram_ctrl  <= '0;
            bus.w_arb_err    <= 1'b0;
`ifdef DRAM_ARB_LOCK_EN
            locked           <= 1'b0;
`endif
        end else begin
            state           <= state_nx;
            bus.w_dram_le   <= 1'b0;
            bus.w_dram_we_t <= 1'b0;
            if (viol)
                bus.w_arb_err <= 1'b1;
            for (int i = 0; i < NHART; i++) begin
                if (cap[i]) begin
                    pend[i]       <= 1'b1;
                    slot_addr[i]  <= bus.w_hart_addr[32*i +: 32];
                    slot_wdata[i] <= bus.w_hart_wdata[32*i +: 32];
                    slot_ctrl[i]  <= bus.w_hart_ctrl[3*i +: 3];
                    slot_wr[i]    <= bus.w_hart_we_t[i];
                end
            end
            case (state)
                IDLE: begin
                    if (found)
                        grant <= sel;
                end
                ISSUE: begin
                    if (!bus.w_dram_busy) begin
                        bus.w_dram_le    <= !slot_wr[grant];
                        bus.w_dram_we_t  <= slot_wr[grant];
                        bus.w_dram_addr  <= slot_addr[grant];
                        bus.w_dram_wdata <= slot_wdata[grant];
                        bus.w_dram_ctrl  <= slot_ctrl[grant];
                        pend[grant]      <= 1'b0;
                        r_seen           <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.w_dram_busy)
                        r_seen <= 1'b1;
                    if (done) begin
                        r_last <= grant;
`ifdef DRAM_ARB_LOCK_EN
                        locked <= bus.w_hart_lock[grant];
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
